// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin write-back arbiter (req_valid/req_rd/req_wd/req_ready in; rf_wen/rf_rd/rf_wd out one cycle after grant) with busy-register scoreboard (iss_valid/iss_rd set, rs1/rs2 -> busy_rs1/busy_rs2)
module wb_arbiter #(
  parameter int XLEN = 64,
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_wd,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_wen,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_wd,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic                 busy_rs1,
  output logic                 busy_rs2
);
  logic [1:0]      ptr;
  logic [1:0]      g;
  logic            any;
  logic [2:0]      idx;
  logic [4:0]      g_rd;
  logic            wen_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] wd_q;
  logic [31:0]     busy;
  always_comb begin
    g = '0;
    any = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = 3'(ptr) + 3'(k);
      idx = idx >= 3'(NREQ) ? idx - 3'(NREQ) : idx;
      if (req_valid[idx[1:0]] && !rst) begin
        any = 1'b1;
        g = idx[1:0];
      end
    end
  end
  assign g_rd      = req_rd[5*g +: 5];
  assign req_ready = any ? {{(NREQ-1){1'b0}}, 1'b1} << g : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      wen_q <= 1'b0;
      busy  <= '0;
    end else begin
      wen_q <= any && g_rd != 5'd0;
      if (any) begin
        ptr  <= g == 2'd2 ? 2'd0 : g + 2'd1;
        rd_q <= g_rd;
        wd_q <= req_wd[XLEN*g +: XLEN];
      end
      if (wen_q) busy[rd_q] <= 1'b0;
      if (iss_valid && iss_rd != 5'd0) busy[iss_rd] <= 1'b1;
    end
  end
  assign rf_wen   = wen_q;
  assign rf_rd    = rd_q;
  assign rf_wd    = wd_q;
  assign busy_rs1 = busy[rs1];
  assign busy_rs2 = busy[rs2];
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized + directed scoreboard bench for wb_arbiter against a behavioural model
module tb_wb_arbiter;
  localparam int XLEN = 64;
  localparam int NREQ = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*5-1:0] req_rd = '0;
  logic [NREQ*XLEN-1:0] req_wd = '0;
  logic [NREQ-1:0] req_ready;
  logic rf_wen;
  logic [4:0] rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic iss_valid = 1'b0;
  logic [4:0] iss_rd = '0;
  logic [4:0] rs1 = '0;
  logic [4:0] rs2 = '0;
  logic busy_rs1, busy_rs2;
  wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_wd(req_wd),
    .req_ready(req_ready), .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
    int              due;
  } wb_t;
  wb_t q[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b0;
  int ptr_m = 0;
  bit [31:0] busy_m = '0;
  logic [4:0] pend_m = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", n, cyc, a, e);
    end
  endtask
  always @(negedge clk) if (mon_on) begin
    while (q.size() > 0 && q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL wb_stale cyc=%0d: write rd=%0d due cyc %0d never seen", cyc, q[0].rd, q[0].due);
      void'(q.pop_front());
    end
    checks++;
    if (rf_wen === 1'b1) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        if (rf_rd !== q[0].rd || rf_wd !== q[0].wd) begin
          errors++;
          $display("FAIL wb_data cyc=%0d: got rd=%0d wd=%0h expected rd=%0d wd=%0h", cyc, rf_rd, rf_wd, q[0].rd, q[0].wd);
        end
        void'(q.pop_front());
      end else begin
        errors++;
        $display("FAIL wb_unexpected cyc=%0d: got rf_wen=1 rd=%0d expected rf_wen=0", cyc, rf_rd);
      end
    end else if (rf_wen !== 1'b0 || (q.size() > 0 && q[0].due == cyc)) begin
      errors++;
      $display("FAIL wb_missing cyc=%0d: got rf_wen=%b expected %0s", cyc, rf_wen, (q.size() > 0 && q[0].due == cyc) ? "1" : "0");
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
    end
  end
  task automatic tick();
    int g;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    g = -1;
    if (!rst)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && req_valid[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
    exp_rdy = (g < 0) ? 3'b000 : 3'b001 << g;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (mon_on) begin
      chk("busy_rs1", 64'(busy_rs1), 64'(busy_m[rs1]));
      chk("busy_rs2", 64'(busy_rs2), 64'(busy_m[rs2]));
    end
    if (g >= 0 && req_rd[5*g +: 5] != 5'd0)
      q.push_back('{req_rd[5*g +: 5], req_wd[XLEN*g +: XLEN], cyc + 1});
    @(posedge clk);
    if (rst) begin
      ptr_m = 0;
      busy_m = '0;
      pend_m = '0;
      q.delete();
    end else begin
      if (pend_m != 5'd0) busy_m[pend_m] = 1'b0;
      if (iss_valid && iss_rd != 5'd0) busy_m[iss_rd] = 1'b1;
      pend_m = (g >= 0) ? req_rd[5*g +: 5] : 5'd0;
      if (g >= 0) ptr_m = (g + 1) % NREQ;
    end
    mon_on = 1'b1;
    #1;
  endtask
  task automatic set_req(input int i, input logic [4:0] rd, input logic [XLEN-1:0] wd);
    req_rd[5*i +: 5] = rd;
    req_wd[XLEN*i +: XLEN] = wd;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_valid = 3'b111;
    iss_valid = 1'b0;
    tick();
    rst = 1'b0;
    req_valid = '0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    do_reset();
    do_reset();
    set_req(1, 5'd5, 64'hAA);
    req_valid = 3'b010;
    tick();
    req_valid = 3'b000;
    rs1 = 5'd5;
    tick();
    set_req(0, 5'd1, 64'h100);
    set_req(1, 5'd2, 64'h200);
    set_req(2, 5'd3, 64'h300);
    req_valid = 3'b111;
    tick();
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      set_req(i % 3, 5'(10 + i), 64'(i * 64'h1111));
      tick();
    end
    req_valid = '0;
    tick();
    set_req(0, 5'd0, 64'hDEAD);
    req_valid = 3'b001;
    rs1 = 5'd0;
    rs2 = 5'd13;
    tick();
    req_valid = '0;
    tick();
    iss_valid = 1'b1;
    iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    rs1 = 5'd7;
    tick();
    set_req(0, 5'd7, 64'h77);
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    tick();
    tick();
    iss_valid = 1'b1;
    iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    set_req(1, 5'd9, 64'h99);
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    iss_valid = 1'b1;
    iss_rd = 5'd9;
    rs1 = 5'd9;
    tick();
    iss_valid = 1'b0;
    tick();
    tick();
    iss_valid = 1'b1;
    iss_rd = 5'd4;
    set_req(1, 5'd6, 64'h66);
    req_valid = 3'b010;
    tick();
    iss_valid = 1'b0;
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rs1 = 5'd4;
    rs2 = 5'd9;
    req_valid = 3'b111;
    tick();
    req_valid = '0;
    tick();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      req_valid = 3'($urandom_range(0, 7));
      for (int r = 0; r < NREQ; r++)
        set_req(r, 5'($urandom_range(0, 31)), {$urandom(), $urandom()});
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      tick();
    end
    rst = 1'b0;
    req_valid = '0;
    iss_valid = 1'b0;
    tick();
    tick();
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
